// File: rtl/renode_apb3_completer.sv
// renode_apb3_completer: APB3 completer turning each transfer into a one-shot back-end request/response.
// Define RENODE_APB3_COMPLETER_TIMEOUT_EN to fail transfers whose back-end stalls for TimeoutCycles.
module renode_apb3_completer #(
    parameter int AddressWidth  = 20,
    parameter int DataWidth     = 32,
    parameter int TimeoutCycles = 256
) (
    input  logic                    pclk,
    input  logic                    presetn,
    input  logic [AddressWidth-1:0] paddr,
    input  logic                    pselx,
    input  logic                    penable,
    input  logic                    pwrite,
    input  logic [DataWidth-1:0]    pwdata,
    output logic                    pready,
    output logic [DataWidth-1:0]    prdata,
    output logic                    pslverr,
    output logic                    req_valid,
    output logic                    req_write,
    output logic [AddressWidth-1:0] req_addr,
    output logic [DataWidth-1:0]    req_wdata,
    input  logic                    rsp_valid,
    input  logic [DataWidth-1:0]    rsp_rdata,
    input  logic                    rsp_error
);
    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_WAIT, S_RESP} state_t;
    state_t state, state_next;
    logic [AddressWidth-1:0] addr_q;
    logic [DataWidth-1:0] wdata_q, rdata_q, rdata_next;
    logic write_q, err_q, err_next, capture, unaligned, timeout;
    assign capture   = pselx && !penable && (state == S_IDLE || state == S_RESP);
    assign unaligned = |(addr_q & AddressWidth'(DataWidth / 8 - 1));
`ifdef RENODE_APB3_COMPLETER_TIMEOUT_EN
    localparam int CW = $clog2(TimeoutCycles + 1);
    logic [CW-1:0] cnt;
    // Counts cycles since req_valid, so the limit is measured from the request pulse.
    always_ff @(posedge pclk or negedge presetn)
        if (!presetn) cnt <= '0;
        else cnt <= (state == S_SETUP || state == S_WAIT) ? cnt + 1'b1 : '0;
    assign timeout = cnt >= CW'(TimeoutCycles - 1);
`else
    logic unused_timeout;
    assign unused_timeout = TimeoutCycles > 0;
    assign timeout = 1'b0;
`endif
    always_comb begin
        state_next = state;
        err_next   = err_q;
        rdata_next = rdata_q;
        case (state)
            S_IDLE: state_next = capture ? S_SETUP : S_IDLE;
            S_SETUP, S_WAIT:
                if (state == S_SETUP && unaligned) begin
                    state_next = S_RESP;
                    err_next   = 1'b1;
                    rdata_next = '0;
                end else if (rsp_valid) begin
                    state_next = S_RESP;
                    err_next   = rsp_error;
                    rdata_next = (write_q || rsp_error) ? '0 : rsp_rdata;
                end else if (timeout) begin
                    state_next = S_RESP;
                    err_next   = 1'b1;
                    rdata_next = '0;
                end else begin
                    state_next = S_WAIT;
                end
            S_RESP: state_next = capture ? S_SETUP : S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state   <= S_IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state   <= state_next;
            err_q   <= err_next;
            rdata_q <= rdata_next;
            if (capture) begin
                addr_q  <= paddr;
                write_q <= pwrite;
                wdata_q <= pwdata;
            end
        end
    end
    assign pready    = state == S_RESP;
    assign pslverr   = pready && err_q;
    assign prdata    = pready ? rdata_q : '0;
    assign req_valid = state == S_SETUP && !unaligned;
    assign req_write = write_q;
    assign req_addr  = addr_q;
    assign req_wdata = wdata_q;
endmodule

// File: tb/tb_renode_apb3_completer.sv
// tb_renode_apb3_completer: directed bench with request/response scoreboards for renode_apb3_completer.
`timescale 1ns/1ps
module tb_renode_apb3_completer;
    logic pclk = 1'b0, presetn = 1'b0;
    logic [19:0] paddr = '0;
    logic pselx = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [31:0] pwdata = '0;
    logic pready, pslverr, req_valid, req_write;
    logic [31:0] prdata, req_wdata;
    logic [19:0] req_addr;
    logic rsp_valid = 1'b0, rsp_error = 1'b0;
    logic [31:0] rsp_rdata = '0;
    int checks = 0, errors = 0;
    int bk_dly = 0;
    logic bk_err = 1'b0;
    logic [31:0] bk_data = '0;
    logic [32:0] rspq[$];
    logic [52:0] reqq[$];

    always #5 pclk = ~pclk;

    renode_apb3_completer #(.AddressWidth(20), .DataWidth(32), .TimeoutCycles(4)) dut (
        .pclk(pclk), .presetn(presetn), .paddr(paddr), .pselx(pselx), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata), .pready(pready), .prdata(prdata), .pslverr(pslverr),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Back-end model: answers each request bk_dly cycles after req_valid (0 = same cycle).
    initial forever begin
        @(negedge pclk);
        rsp_valid = 1'b0;
        rsp_error = 1'b0;
        rsp_rdata = '0;
        if (req_valid) begin
            repeat (bk_dly) @(negedge pclk);
            rsp_valid = 1'b1;
            rsp_error = bk_err;
            rsp_rdata = bk_data;
        end
    end

    initial forever begin
        logic [52:0] eq;
        logic [32:0] er;
        @(negedge pclk);
        if (req_valid) begin
            if (reqq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL req_unexpected: got req_valid=1 addr %h expected req_valid=0", req_addr);
            end else begin
                eq = reqq.pop_front();
                chk("request", 64'({req_write, req_addr, req_wdata}), 64'(eq));
            end
        end
        if (pready) begin
            if (rspq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected: got pready=1 expected pready=0");
            end else begin
                er = rspq.pop_front();
                chk("response", 64'({prdata, pslverr}), 64'(er));
            end
        end else begin
            chk("idle_quiet", 64'({prdata, pslverr}), 64'd0);
        end
    end

    task automatic xfer(input logic w, input logic [19:0] a, input logic [31:0] d, input int dly,
                        input logic e, input logic [31:0] rd, input logic [32:0] exp_rsp,
                        input int exp_lat, input bit b2b);
        int n;
        bk_dly = dly;
        bk_err = e;
        bk_data = rd;
        if (a[1:0] == 2'b00) reqq.push_back({w, a, d});
        rspq.push_back(exp_rsp);
        pselx = 1'b1;
        penable = 1'b0;
        pwrite = w;
        paddr = a;
        pwdata = d;
        @(negedge pclk);
        penable = 1'b1;
        n = 0;
        while (!pready && n < 64) begin
            @(negedge pclk);
            n++;
        end
        chk("latency", 64'(n), 64'(exp_lat));
        if (!b2b) begin
            @(negedge pclk);
            pselx = 1'b0;
            penable = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200us");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge pclk);
        chk("rst_pready", 64'(pready), 64'd0);
        chk("rst_req_valid", 64'(req_valid), 64'd0);
        chk("rst_req", 64'({req_write, req_addr, req_wdata}), 64'd0);
        presetn = 1'b1;
        @(negedge pclk);
        xfer(1'b1, 20'h104, 32'hDEADBEEF, 0, 1'b0, 32'h0, {32'h0, 1'b0}, 1, 1'b0);
        xfer(1'b0, 20'h200, 32'h0, 5, 1'b0, 32'h12345678, {32'h12345678, 1'b0}, 6, 1'b0);
        xfer(1'b0, 20'h102, 32'h0, 0, 1'b0, 32'h99, {32'h0, 1'b1}, 1, 1'b0);
        xfer(1'b1, 20'h300, 32'hA5A5, 2, 1'b1, 32'h0, {32'h0, 1'b1}, 3, 1'b0);
        xfer(1'b0, 20'h304, 32'h0, 1, 1'b0, 32'hCAFEF00D, {32'hCAFEF00D, 1'b0}, 2, 1'b0);
        xfer(1'b0, 20'h008, 32'h0, 0, 1'b1, 32'hFFFFFFFF, {32'h0, 1'b1}, 1, 1'b0);
        xfer(1'b0, 20'h400, 32'h0, 0, 1'b0, 32'h11111111, {32'h11111111, 1'b0}, 1, 1'b1);
        xfer(1'b0, 20'h404, 32'h0, 0, 1'b0, 32'h22222222, {32'h22222222, 1'b0}, 1, 1'b0);
        // Reset while the back-end is still working; its late response must be dropped.
        bk_dly = 6;
        bk_err = 1'b0;
        bk_data = 32'h33333333;
        reqq.push_back({1'b1, 20'h700, 32'h3C3C3C3C});
        pselx = 1'b1;
        penable = 1'b0;
        pwrite = 1'b1;
        paddr = 20'h700;
        pwdata = 32'h3C3C3C3C;
        @(negedge pclk);
        penable = 1'b1;
        repeat (2) @(negedge pclk);
        #2 presetn = 1'b0;
        #1;
        chk("arst_req", 64'({req_valid, req_write, req_addr, req_wdata}), 64'd0);
        chk("arst_apb", 64'({pready, pslverr, prdata}), 64'd0);
        pselx = 1'b0;
        penable = 1'b0;
        repeat (2) @(negedge pclk);
        presetn = 1'b1;
        repeat (6) @(negedge pclk);
        xfer(1'b1, 20'h504, 32'h55, 0, 1'b0, 32'h0, {32'h0, 1'b0}, 1, 1'b0);
`ifdef RENODE_APB3_COMPLETER_TIMEOUT_EN
        xfer(1'b0, 20'h600, 32'h0, 8, 1'b0, 32'h77, {32'h0, 1'b1}, 4, 1'b0);
`else
        xfer(1'b0, 20'h600, 32'h0, 8, 1'b0, 32'h77, {32'h77, 1'b0}, 9, 1'b0);
`endif
        repeat (12) @(negedge pclk);
        chk("queues_empty", 64'(reqq.size() + rspq.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
